// File: rtl/stage_sequencer.sv
// Multi-cycle control sequencer: owns the PC, fetches over imem req/ack, waits on
// dmem for loads/stores, resolves jumps and exposes the current stage downstream.
module stage_sequencer #(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter logic [4:0]  TYPE_ALU      = 5'd0,
   parameter logic [4:0]  TYPE_LOAD_IMM = 5'd1,
   parameter logic [4:0]  TYPE_LOAD     = 5'd2,
   parameter logic [4:0]  TYPE_STORE    = 5'd3,
   parameter logic [4:0]  TYPE_JUMP     = 5'd4,
   parameter logic [4:0]  TYPE_HALT     = 5'd5
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] current_instruction,
   input  logic [4:0]  decoded_type,
   output logic [4:0]  current_instruction_type,
   output logic        dmem_req,
   input  logic        dmem_ack,
   input  logic [31:0] jump_condition,
   input  logic [31:0] jump_target,
   output logic [2:0]  stage,
   output logic [31:0] pc,
   output logic        halted,
   output logic        illegal_instr,
   output logic [31:0] retired_count
);

   typedef enum logic [2:0] {
      FETCH      = 3'd0,
      DECODE     = 3'd1,
      EXECUTE    = 3'd2,
      MEM_WAIT   = 3'd3,
      REG_UPDATE = 3'd4,
      PC_UPDATE  = 3'd5,
      HALTED     = 3'd6
   } stage_e;

   stage_e      stage_q;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q;
   logic [31:0] retired_q, retired_d;
   logic [4:0]  type_q;
   logic        halted_q, illegal_q;
   logic        jump_taken;
   logic        unused_jt_low;

   // Jump targets are word-aligned; the low two bits of the register are dropped.
   assign jump_taken    = (type_q == TYPE_JUMP) && (jump_condition != 32'd0);
   assign pc_d          = jump_taken ? {jump_target[31:2], 2'b00} : pc_q + 32'd4;
   assign retired_d     = retired_q + 32'd1;
   assign unused_jt_low = ^jump_target[1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         stage_q   <= FETCH;
         pc_q      <= RESET_PC;
         instr_q   <= 32'd0;
         type_q    <= 5'd0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
         retired_q <= 32'd0;
      end else begin
         case (stage_q)
            FETCH: begin
               if (imem_ack) begin
                  instr_q <= imem_rdata;
                  stage_q <= DECODE;
               end
            end
            DECODE: begin
               type_q  <= decoded_type;
               stage_q <= EXECUTE;
            end
            EXECUTE: begin
               if (type_q == TYPE_LOAD || type_q == TYPE_STORE) begin
                  stage_q <= MEM_WAIT;
               end else if (type_q == TYPE_ALU || type_q == TYPE_LOAD_IMM) begin
                  stage_q <= REG_UPDATE;
               end else if (type_q == TYPE_JUMP) begin
                  stage_q <= PC_UPDATE;
               end else if (type_q == TYPE_HALT) begin
                  stage_q  <= HALTED;
                  halted_q <= 1'b1;
               end else begin
                  stage_q   <= HALTED;
                  halted_q  <= 1'b1;
                  illegal_q <= 1'b1;
               end
            end
            MEM_WAIT: begin
               if (dmem_ack) begin
                  stage_q <= (type_q == TYPE_LOAD) ? REG_UPDATE : PC_UPDATE;
               end
            end
            REG_UPDATE: begin
               stage_q <= PC_UPDATE;
            end
            PC_UPDATE: begin
               pc_q      <= pc_d;
               retired_q <= retired_d;
               stage_q   <= FETCH;
            end
            HALTED: begin
               stage_q <= HALTED;
            end
            default: begin
               stage_q <= FETCH;
            end
         endcase
      end
   end

   assign imem_req                 = (stage_q == FETCH);
   assign dmem_req                 = (stage_q == MEM_WAIT);
   assign stage                    = stage_q;
   assign pc                       = pc_q;
   assign current_instruction      = instr_q;
   assign current_instruction_type = type_q;
   assign halted                   = halted_q;
   assign illegal_instr            = illegal_q;
   assign retired_count            = retired_q;

endmodule
